// File: rtl/synth_pkg.sv
// Shared constants and parser state encoding for the PS/2 -> voice allocation path.
package synth_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_SILENT = 8'hF0;
    localparam int         N_VOICES  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_e;

endpackage

// File: rtl/scan_prefix_fsm.sv
// Tracks PS/2 break/extended prefixes and turns bytes into one-cycle make/break events.
module scan_prefix_fsm
    import synth_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       make_ev,
    output logic       break_ev,
    output logic [7:0] key
);

    parse_state_e state_q, state_d;

    always_comb begin
        state_d  = state_q;
        make_ev  = 1'b0;
        break_ev = 1'b0;
        key      = scan_code;
        if (scan_ready) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = BRK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = EXT;
                    end else begin
                        // 00 and FF are keyboard error/overrun bytes, never notes.
                        make_ev = (scan_code != 8'h00) && (scan_code != 8'hFF);
                    end
                end
                BRK: begin
                    break_ev = 1'b1;
                    state_d  = IDLE;
                end
                EXT: begin
                    state_d = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Four-voice key allocator: assigns pressed keys to free channels, steals round-robin when full.
module voice_allocator #(
    parameter int N_VOICES = 4
) (
    input  logic                VGA_CLK,
    input  logic                reset,
    input  logic [7:0]          scan_code,
    input  logic                scan_ready,
    output logic [7:0]          scan_code1,
    output logic [7:0]          scan_code2,
    output logic [7:0]          scan_code3,
    output logic [7:0]          scan_code4,
    output logic [N_VOICES-1:0] voice_busy,
    output logic [1:0]          steal_ptr
);

    import synth_pkg::*;

    logic       make_ev;
    logic       break_ev;
    logic [7:0] key;

    scan_prefix_fsm u_prefix (
        .clk        (VGA_CLK),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .make_ev    (make_ev),
        .break_ev   (break_ev),
        .key        (key)
    );

    logic [7:0]          code_q [N_VOICES];
    logic [7:0]          code_d [N_VOICES];
    logic [N_VOICES-1:0] busy_q, busy_d;
    logic [1:0]          steal_q, steal_d;
    logic [N_VOICES-1:0] hit;
    logic [1:0]          free_idx;

    always_comb begin
        for (int i = 0; i < N_VOICES; i++) begin
            code_d[i] = code_q[i];
            hit[i]    = busy_q[i] && (code_q[i] == key);
        end
        busy_d  = busy_q;
        steal_d = steal_q;

        // Descending scan leaves the lowest-index free channel selected.
        free_idx = '0;
        for (int i = N_VOICES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = 2'(i);
            end
        end

        if (make_ev && (hit == '0)) begin
            if (busy_q != '1) begin
                code_d[free_idx] = key;
                busy_d[free_idx] = 1'b1;
            end else begin
                code_d[steal_q] = key;
                steal_d         = steal_q + 2'd1;
            end
        end

        if (break_ev) begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (hit[i]) begin
                    code_d[i] = SC_SILENT;
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            for (int i = 0; i < N_VOICES; i++) begin
                code_q[i] <= SC_SILENT;
            end
            busy_q  <= '0;
            steal_q <= '0;
        end else begin
            for (int i = 0; i < N_VOICES; i++) begin
                code_q[i] <= code_d[i];
            end
            busy_q  <= busy_d;
            steal_q <= steal_d;
        end
    end

    assign scan_code1 = code_q[0];
    assign scan_code2 = code_q[1];
    assign scan_code3 = code_q[2];
    assign scan_code4 = code_q[3];
    assign voice_busy = busy_q;
    assign steal_ptr  = steal_q;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Four-voice allocator between the PS/2 keyboard byte stream and the four-channel note decoder (`staff`). It parses make/break/extended prefixes, assigns each newly pressed key to a free channel, and releases that channel on key-up. When all four channels are busy, it steals one round-robin. Its four registered per-channel scan codes drive `scan_code1..4` of the decoder directly. 8'hF0 on a channel means "silent".

## Interface
Parameters:
- `N_VOICES`, 4, number of channels; fixed at 4 in this revision.

Ports:
- `VGA_CLK`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `scan_code`  in  8  received PS/2 byte.
- `scan_ready`  in  1  one-cycle strobe; `scan_code` is valid this cycle.
- `scan_code1..scan_code4`  out  8 each  per-channel key code to the note decoder; 8'hF0 = silent.
- `voice_busy`  out  4  bit i = channel i+1 holds a key.
- `steal_ptr`  out  2  next channel to steal (debug/visibility).

## Operation
- Byte parser FSM, advancing only on `scan_ready`:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte -> make event.
  - BRK: any byte -> break event, then IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> discard, then IDLE.
  - EXT_BRK: any byte -> discard, then IDLE.
- Codes 8'h00, 8'hFF, 8'hF0 and 8'hE0 are never stored as notes. A make event carrying 8'h00 or 8'hFF is discarded.
- Make event with code K, evaluated in priority order:
  1. K already held by a busy channel (typematic repeat): no change.
  2. Otherwise, at least one channel free: load K into the lowest-index free channel and set its busy bit. `steal_ptr` is unchanged.
  3. Otherwise (all busy): load K into channel `steal_ptr+1`, keep it busy, and increment `steal_ptr` mod 4.
- Break event with code K:
  - Every busy channel holding K is loaded with 8'hF0 and its busy bit cleared. Normally there is exactly one such channel.
  - If no channel holds K: no change.
- Silent channels hold 8'hF0. A free channel always outputs 8'hF0.

## Timing
- Reset values: all `scan_codeN` = 8'hF0, `voice_busy` = 4'b0000, `steal_ptr` = 0, FSM = IDLE.
- Reset mid-sequence (e.g. reset asserted while in BRK) returns to IDLE. A byte strobed in the same cycle as reset is dropped.
- Latency: the byte strobed in cycle n updates `scan_codeN`/`voice_busy` at the clock edge ending cycle n, so the new value is visible in cycle n+1.
- Prefix bytes (F0, E0) cause no output change.
- Only one byte is accepted per cycle. `scan_ready` high on consecutive cycles is legal, and each byte is processed.
- All outputs are registered. There is no combinational path from `scan_code` to the outputs.
- Wrap-around: `steal_ptr` goes 3 -> 0.

## Structure
- Shared package `synth_pkg`:
  - constants `SC_BREAK` = 8'hF0, `SC_EXT` = 8'hE0, `SC_SILENT` = 8'hF0, `N_VOICES` = 4;
  - parser state enum {IDLE, BRK, EXT, EXT_BRK}.
- Sub-module `scan_prefix_fsm`: consumes `scan_code`/`scan_ready` and emits one-cycle `make_ev`, `break_ev` and an 8-bit `key`. It is combinational on its state register, so the allocator is still registered, one cycle after the strobe.
- The allocator proper contains:
  - hit detect: 4 comparators;
  - lowest-free priority encoder;
  - steal pointer;
  - 4x8 code registers.

## Test plan
- Reset, then idle: all `scan_codeN` = F0, `voice_busy` = 0000, `steal_ptr` = 0.
- Bytes 1C, 1B, 23 -> channels 1, 2, 3 = 1C, 1B, 23; `voice_busy` = 0111. Then F0, 1B -> ch2 = F0, `voice_busy` = 0101. Then 2B -> ch2 = 2B.
- Repeat 1C five times with 1C held -> no output change, `voice_busy` unchanged.
- Fill all four channels (1C, 1B, 23, 2B), then 34 -> ch1 = 34, `steal_ptr` = 1. Then 33 -> ch2 = 33, `steal_ptr` = 2. Four more steals -> pointer wraps to 2.
- E0, 75 and E0, F0, 75 -> no output change. F0, 42 with 42 not held -> no change.
- Reset asserted between F0 and 1C while 1C is held -> all channels F0. The following 1C is treated as a make -> ch1 = 1C.
